// File: rtl/bt_update_queue.sv
// Branch-target update queue: collects ALU BTUpdate records, merges same-src updates,
// and drains one record per cycle into the BTB write port.
package bt_update_queue_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] src;
      logic [31:0] dst;
      logic        isJump;
      logic        isCall;
      logic        compressed;
      logic        clean;
      logic        multiple;
      logic [2:0]  multipleOffs;
      logic [2:0]  fetchStartOffs;
   } bt_update_t;
endpackage

module bt_update_queue
   import bt_update_queue_pkg::*;
#(
   parameter int unsigned NUM_IN = 2,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  bt_update_t       IN_btUpdate [NUM_IN],
   input  logic             IN_clear,
   input  logic             IN_btReady,
   output bt_update_t       OUT_btUpdate,
   output logic             OUT_full,
   output logic [CNT_W-1:0] OUT_dropCnt
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_QW = PTR_W + 1;
   localparam int unsigned DROP_W = $clog2(NUM_IN + 1);

   bt_update_t              ent      [DEPTH];
   bt_update_t              nxt_ent  [DEPTH];
   logic [DEPTH-1:0]        vld, nxt_vld;
   logic [PTR_W-1:0]        head, nxt_head, tail, nxt_tail;
   logic [CNT_QW-1:0]       cnt, nxt_cnt;
   logic [CNT_W-1:0]        drop_cnt, nxt_drop_cnt;
   logic [DROP_W-1:0]       n_drop;
   logic [CNT_W:0]          drop_sum;
   logic                    pop, hit;
   logic [PTR_W-1:0]        hit_idx;
   bt_update_t              out_q, nxt_out;
   logic                    full_q;

   // Next-state: clear, else pop then port-ordered merge / allocate / drop.
   always_comb begin
      nxt_ent      = ent;
      nxt_vld      = vld;
      nxt_head     = head;
      nxt_tail     = tail;
      nxt_cnt      = cnt;
      nxt_drop_cnt = drop_cnt;
      n_drop       = '0;
      drop_sum     = '0;
      hit          = 1'b0;
      hit_idx      = '0;
      pop          = out_q.valid && IN_btReady;

      if (IN_clear) begin
         nxt_vld  = '0;
         nxt_head = '0;
         nxt_tail = '0;
         nxt_cnt  = '0;
      end else begin
         if (pop) begin
            nxt_vld[head] = 1'b0;
            nxt_head      = head + PTR_W'(1);
            nxt_cnt       = cnt - CNT_QW'(1);
         end
         for (int p = 0; p < NUM_IN; p++) begin
            if (IN_btUpdate[p].valid) begin
               hit     = 1'b0;
               hit_idx = '0;
               for (int i = 0; i < DEPTH; i++) begin
                  if (nxt_vld[i] && nxt_ent[i].src == IN_btUpdate[p].src) begin
                     hit     = 1'b1;
                     hit_idx = PTR_W'(i);
                  end
               end
               if (hit) begin
                  nxt_ent[hit_idx].dst            = IN_btUpdate[p].dst;
                  nxt_ent[hit_idx].isJump         = IN_btUpdate[p].isJump;
                  nxt_ent[hit_idx].isCall         = IN_btUpdate[p].isCall;
                  nxt_ent[hit_idx].compressed     = IN_btUpdate[p].compressed;
                  nxt_ent[hit_idx].multiple       = IN_btUpdate[p].multiple;
                  nxt_ent[hit_idx].multipleOffs   = IN_btUpdate[p].multipleOffs;
                  nxt_ent[hit_idx].fetchStartOffs = IN_btUpdate[p].fetchStartOffs;
               end else if (nxt_cnt < CNT_QW'(DEPTH)) begin
                  nxt_ent[nxt_tail] = IN_btUpdate[p];
                  nxt_vld[nxt_tail] = 1'b1;
                  nxt_tail          = nxt_tail + PTR_W'(1);
                  nxt_cnt           = nxt_cnt + CNT_QW'(1);
               end else begin
                  n_drop = n_drop + DROP_W'(1);
               end
            end
         end
         drop_sum     = (CNT_W+1)'(drop_cnt) + (CNT_W+1)'(n_drop);
         nxt_drop_cnt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end

      nxt_out       = nxt_ent[nxt_head];
      nxt_out.valid = (nxt_cnt != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         vld      <= '0;
         head     <= '0;
         tail     <= '0;
         cnt      <= '0;
         drop_cnt <= '0;
         out_q    <= '0;
         full_q   <= 1'b0;
      end else begin
         ent      <= nxt_ent;
         vld      <= nxt_vld;
         head     <= nxt_head;
         tail     <= nxt_tail;
         cnt      <= nxt_cnt;
         drop_cnt <= nxt_drop_cnt;
         out_q    <= nxt_out;
         full_q   <= (nxt_cnt == CNT_QW'(DEPTH));
      end
   end

   assign OUT_btUpdate = out_q;
   assign OUT_full     = full_q;
   assign OUT_dropCnt  = drop_cnt;

endmodule

// File: tb/tb_bt_update_queue.sv
// Scoreboard bench for bt_update_queue: stimulus queues expected pops, a monitor compares them.
module tb_bt_update_queue;
   import bt_update_queue_pkg::*;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   bt_update_t upd [2];
   logic       clr = 1'b0;
   logic       rdy = 1'b0;
   bt_update_t out;
   logic       full;
   logic [7:0] drop;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   bt_update_queue #(.NUM_IN(2), .DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .IN_btUpdate(upd), .IN_clear(clr),
      .IN_btReady(rdy), .OUT_btUpdate(out), .OUT_full(full), .OUT_dropCnt(drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int p, input logic [31:0] src, input logic [31:0] dst);
      upd[p]       = '0;
      upd[p].valid = 1'b1;
      upd[p].src   = src;
      upd[p].dst   = dst;
   endtask

   task automatic clr_in();
      upd[0] = '0;
      upd[1] = '0;
   endtask

   task automatic expect_pop(input logic [31:0] src, input logic [31:0] dst);
      exp_t e;
      e.src = src;
      e.dst = dst;
      sb.push_back(e);
   endtask

   // Monitor: a record is consumed at the next edge when valid && ready && !clear.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && out.valid && rdy && !clr) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: got src 0x%0h dst 0x%0h, expected no record", out.src, out.dst);
            end else begin
               e = sb.pop_front();
               if (out.src !== e.src || out.dst !== e.dst) begin
                  errors++;
                  $display("FAIL pop: got src 0x%0h dst 0x%0h, expected src 0x%0h dst 0x%0h",
                           out.src, out.dst, e.src, e.dst);
               end
            end
         end
      end
   end

   initial begin
      clr_in();
      #2;
      check("rst_valid", 32'(out.valid), 32'h0);
      check("rst_full", 32'(full), 32'h0);
      check("rst_drop", 32'(drop), 32'h0);
      #10 rst = 1'b1;
      tick();

      // Single push, held with ready low
      set_in(0, 32'h1000, 32'h2000);
      tick();
      clr_in();
      check("single_valid", 32'(out.valid), 32'h1);
      check("single_src", out.src, 32'h1000);
      check("single_dst", out.dst, 32'h2000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_src", out.src, 32'h1000);
         check("hold_valid", 32'(out.valid), 32'h1);
      end
      check("single_full", 32'(full), 32'h0);
      expect_pop(32'h1000, 32'h2000);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check("single_empty", 32'(out.valid), 32'h0);

      // Dual push then drain
      set_in(0, 32'h100, 32'h1);
      set_in(1, 32'h200, 32'h2);
      tick();
      clr_in();
      expect_pop(32'h100, 32'h1);
      expect_pop(32'h200, 32'h2);
      rdy = 1'b1;
      tick();
      check("dual_second", out.src, 32'h200);
      tick();
      rdy = 1'b0;
      check("dual_empty", 32'(out.valid), 32'h0);

      // Merge into queued entry, then same-cycle duplicate src
      set_in(0, 32'h300, 32'h400);
      tick();
      set_in(0, 32'h300, 32'h500);
      tick();
      set_in(0, 32'h600, 32'h10);
      set_in(1, 32'h600, 32'h20);
      tick();
      set_in(0, 32'h700, 32'h7);
      set_in(1, 32'h800, 32'h8);
      tick();
      clr_in();
      check("merge_full", 32'(full), 32'h1);
      check("merge_drop", 32'(drop), 32'h0);
      expect_pop(32'h300, 32'h500);
      expect_pop(32'h600, 32'h20);
      expect_pop(32'h700, 32'h7);
      expect_pop(32'h800, 32'h8);
      rdy = 1'b1;
      repeat (4) tick();
      rdy = 1'b0;
      check("merge_empty", 32'(out.valid), 32'h0);

      // Full with simultaneous pop: port0 takes the freed slot, port1 dropped
      set_in(0, 32'hA0, 32'h0);
      set_in(1, 32'hA1, 32'h1);
      tick();
      set_in(0, 32'hA2, 32'h2);
      set_in(1, 32'hA3, 32'h3);
      tick();
      check("fill_full", 32'(full), 32'h1);
      set_in(0, 32'hB0, 32'h10);
      set_in(1, 32'hB1, 32'h11);
      expect_pop(32'hA0, 32'h0);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      clr_in();
      check("ovf_drop", 32'(drop), 32'h1);
      check("ovf_full", 32'(full), 32'h1);
      check("ovf_head", out.src, 32'hA1);

      // Saturation of the drop counter
      for (int i = 0; i < 200; i++) begin
         set_in(0, 32'hC000 + 32'(2 * i), 32'h0);
         set_in(1, 32'hC001 + 32'(2 * i), 32'h0);
         tick();
      end
      clr_in();
      check("sat_drop", 32'(drop), 32'hFF);
      check("sat_full", 32'(full), 32'h1);
      set_in(0, 32'hD000, 32'h0);
      set_in(1, 32'hD001, 32'h0);
      repeat (5) tick();
      clr_in();
      check("sat_hold", 32'(drop), 32'hFF);
      expect_pop(32'hA1, 32'h1);
      expect_pop(32'hA2, 32'h2);
      expect_pop(32'hA3, 32'h3);
      expect_pop(32'hB0, 32'h10);
      rdy = 1'b1;
      repeat (4) tick();
      rdy = 1'b0;
      check("sat_empty", 32'(out.valid), 32'h0);

      // Clear beats push and pop
      set_in(0, 32'hE0, 32'h0);
      set_in(1, 32'hE1, 32'h0);
      tick();
      set_in(0, 32'hE2, 32'h0);
      set_in(1, 32'hFFFF_0000, 32'h0);
      upd[1].valid = 1'b0;
      tick();
      set_in(0, 32'hE3, 32'h0);
      clr = 1'b1;
      rdy = 1'b1;
      tick();
      clr = 1'b0;
      rdy = 1'b0;
      clr_in();
      check("clr_valid", 32'(out.valid), 32'h0);
      check("clr_full", 32'(full), 32'h0);
      check("clr_drop", 32'(drop), 32'hFF);
      set_in(0, 32'hF0, 32'hF1);
      tick();
      clr_in();
      check("post_clr_src", out.src, 32'hF0);
      expect_pop(32'hF0, 32'hF1);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check("post_clr_empty", 32'(out.valid), 32'h0);

      // Asynchronous reset mid-drain
      set_in(0, 32'h1A, 32'h1);
      set_in(1, 32'h1B, 32'h2);
      tick();
      clr_in();
      expect_pop(32'h1A, 32'h1);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check("drain_head", out.src, 32'h1B);
      #1 rst = 1'b0;
      #1;
      check("arst_valid", 32'(out.valid), 32'h0);
      check("arst_full", 32'(full), 32'h0);
      check("arst_drop", 32'(drop), 32'h0);
      #10 rst = 1'b1;
      tick();
      check("arst_stay_empty", 32'(out.valid), 32'h0);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
